// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared types and defaults for the hiscore upload path
package pacman_pkg;
   typedef enum logic [1:0] {IDLE, REQ, LAT} state_t;
   localparam logic [7:0] UP_INDEX_DEF   = 8'd4;
   localparam int         HISCORE_ADDR_W = 10;
endpackage

// File: rtl/upload_edge_det.sv
// rtl/upload_edge_det.sv - registered rise/fall detector on the upload select
module upload_edge_det (
   input  logic CLK,
   input  logic RESET,
   input  logic sel,
   output logic rise,
   output logic fall
);
   logic sel_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) sel_q <= 1'b0;
      else       sel_q <= sel;
   end

   assign rise = sel & ~sel_q;
   assign fall = ~sel & sel_q;
endmodule

// File: rtl/hiscore_upload_reader.sv
// rtl/hiscore_upload_reader.sv - serves HPS ioctl upload reads from core RAM
// Stalls the HPS with ioctl_wait until the arbitrated RAM port returns data.
module hiscore_upload_reader
   import pacman_pkg::*;
#(
   parameter int         ADDR_W   = HISCORE_ADDR_W,
   parameter int         RAM_LAT  = 1,
   parameter logic [7:0] UP_INDEX = UP_INDEX_DEF
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              ram_req,
   input  logic              ram_ack,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_q,
   output logic [ADDR_W:0]   byte_count,
   output logic              rd_overrun,
   output logic              done
);
   localparam logic [ADDR_W:0] FULL     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [1:0]      LAT_INIT = 2'(RAM_LAT - 1);

   state_t     state;
   logic [1:0] lat_cnt;
   logic       sel, rise, fall, in_range;

   assign sel      = ioctl_upload & (ioctl_index == UP_INDEX);
   assign in_range = (ioctl_addr[24:ADDR_W] == '0);

   upload_edge_det u_edge (
      .CLK   (CLK),
      .RESET (RESET),
      .sel   (sel),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         lat_cnt    <= 2'd0;
         ioctl_din  <= 8'd0;
         ioctl_wait <= 1'b0;
         ram_req    <= 1'b0;
         ram_addr   <= '0;
         byte_count <= '0;
         rd_overrun <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fall) begin
            // Session end aborts any in-flight read, including a same-cycle grant.
            state      <= IDLE;
            ram_req    <= 1'b0;
            ioctl_wait <= 1'b0;
            done       <= (byte_count == FULL);
         end else if (sel) begin
            if (rise) begin
               byte_count <= '0;
               rd_overrun <= 1'b0;
            end
            case (state)
               IDLE: begin
                  if (ioctl_rd) begin
                     if (!in_range) begin
                        ioctl_din <= 8'hFF;
                     end else begin
                        ram_addr   <= ioctl_addr[ADDR_W-1:0];
                        ioctl_wait <= 1'b1;
                        ram_req    <= 1'b1;
                        state      <= REQ;
                     end
                  end
               end
               REQ: begin
                  if (ioctl_rd) rd_overrun <= 1'b1;
                  if (ram_ack) begin
                     ram_req <= 1'b0;
                     lat_cnt <= LAT_INIT;
                     state   <= LAT;
                  end
               end
               LAT: begin
                  if (ioctl_rd) rd_overrun <= 1'b1;
                  if (lat_cnt == 2'd0) begin
                     ioctl_din  <= ram_q;
                     ioctl_wait <= 1'b0;
                     if (byte_count != FULL) byte_count <= byte_count + 1'b1;
                     state      <= IDLE;
                  end else begin
                     lat_cnt <= lat_cnt - 2'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hiscore_upload_reader.sv
// tb/tb_hiscore_upload_reader.sv - directed checks for hiscore_upload_reader at RAM_LAT 1 and 3
module tb_hiscore_upload_reader;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        ioctl_upload = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_rd = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic        ram_ack = 1'b0;
   logic [7:0]  ram_q = 8'd0;

   logic [7:0]  din1, din3;
   logic        wait1, wait3, req1, req3, ovr1, ovr3, done1, done3;
   logic [9:0]  raddr1, raddr3;
   logic [10:0] cnt1, cnt3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   hiscore_upload_reader #(.ADDR_W(10), .RAM_LAT(1), .UP_INDEX(8'd4)) u1 (
      .CLK(CLK), .RESET(RESET), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din1), .ioctl_wait(wait1),
      .ram_req(req1), .ram_ack(ram_ack), .ram_addr(raddr1), .ram_q(ram_q),
      .byte_count(cnt1), .rd_overrun(ovr1), .done(done1));

   hiscore_upload_reader #(.ADDR_W(10), .RAM_LAT(3), .UP_INDEX(8'd4)) u3 (
      .CLK(CLK), .RESET(RESET), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din3), .ioctl_wait(wait3),
      .ram_req(req3), .ram_ack(ram_ack), .ram_addr(raddr3), .ram_q(ram_q),
      .byte_count(cnt3), .rd_overrun(ovr3), .done(done3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One in-range read with grant in the cycle after rd; returns once both DUTs released wait.
   task automatic do_read(input logic [24:0] addr, input logic [7:0] q);
      int n;
      ram_q      = q;
      ioctl_addr = addr;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      ram_ack  = 1'b1;
      tick();
      ram_ack = 1'b0;
      n = 0;
      while ((wait1 || wait3) && n < 10) begin
         tick();
         n++;
      end
      if (wait1 || wait3) check("read_timeout", 32'(wait1 | wait3), 0);
   endtask

   int wait_hi, req_hi, done_n;

   initial begin
      // reset state
      #12;
      check("rst_din", din1, 8'h00);
      check("rst_wait", wait1, 0);
      check("rst_req", req1, 0);
      check("rst_cnt", cnt1, 0);
      check("rst_done", done1, 0);
      @(negedge CLK);
      RESET = 1'b0;

      // immediate grant, RAM_LAT 1 and 3
      ioctl_upload = 1'b1;
      ioctl_index  = 8'd4;
      ram_q        = 8'hA5;
      tick();
      ioctl_addr = 25'h005;
      ioctl_rd   = 1'b1;
      tick();
      check("t1_c1_wait", wait1, 1);
      check("t1_c1_req", req1, 1);
      check("t1_ram_addr", raddr1, 10'h005);
      ioctl_rd = 1'b0;
      ram_ack  = 1'b1;
      tick();
      ram_ack = 1'b0;
      check("t1_c2_wait", wait1, 1);
      check("t1_c2_req", req1, 0);
      tick();
      check("t1_c3_wait", wait1, 0);
      check("t1_c3_din", din1, 8'hA5);
      check("t1_c3_cnt", cnt1, 1);
      check("t1_c3_wait3", wait3, 1);
      tick();
      check("t1_c4_wait3", wait3, 1);
      tick();
      check("t1_c5_wait3", wait3, 0);
      check("t1_c5_din3", din3, 8'hA5);
      check("t1_c5_cnt3", cnt3, 1);

      // grant held off to cycle 10, RAM_LAT 3
      ram_q      = 8'h3C;
      ioctl_addr = 25'h012;
      ioctl_rd   = 1'b1;
      wait_hi = 0;
      req_hi  = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         ioctl_rd = 1'b0;
         if (wait3) wait_hi++;
         if (req3) req_hi++;
         if (c == 11) check("t2_req_low", req3, 0);
         if (c == 13) check("t2_din_before", din3, 8'hA5);
         if (c == 14) check("t2_din_after", din3, 8'h3C);
         ram_ack = (c == 10);
      end
      check("t2_wait_cycles", wait_hi, 13);
      check("t2_req_cycles", req_hi, 10);
      check("t2_cnt3", cnt3, 2);
      check("t2_din1", din1, 8'h3C);

      // out of range
      ioctl_addr = 25'h400;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      check("t3_din1", din1, 8'hFF);
      check("t3_din3", din3, 8'hFF);
      wait_hi = 0;
      for (int c = 0; c < 4; c++) begin
         if (wait1 || wait3 || req1 || req3) wait_hi++;
         tick();
      end
      check("t3_no_wait_req", wait_hi, 0);
      check("t3_cnt1", cnt1, 2);

      // abort while in REQ
      ioctl_addr = 25'h007;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd     = 1'b0;
      ioctl_upload = 1'b0;
      tick();
      check("t4_req", req1, 0);
      check("t4_wait", wait1, 0);
      check("t4_din", din1, 8'hFF);
      check("t4_cnt", cnt1, 2);
      check("t4_done", done1, 0);

      // abort in the same cycle as the grant
      ioctl_upload = 1'b1;
      tick();
      ioctl_rd = 1'b1;
      ram_q    = 8'h77;
      tick();
      ioctl_rd     = 1'b0;
      ram_ack      = 1'b1;
      ioctl_upload = 1'b0;
      tick();
      ram_ack = 1'b0;
      tick();
      tick();
      tick();
      check("t4b_wait1", wait1, 0);
      check("t4b_wait3", wait3, 0);
      check("t4b_req3", req3, 0);
      check("t4b_din1", din1, 8'hFF);
      check("t4b_din3", din3, 8'hFF);
      check("t4b_cnt", cnt1, 0);

      // rd during LAT sets overrun, in-flight read completes
      ioctl_upload = 1'b1;
      ram_q        = 8'h5A;
      tick();
      check("t5_ovr_clr", ovr1, 0);
      ioctl_addr = 25'h009;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      ram_ack  = 1'b1;
      tick();
      ram_ack  = 1'b0;
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      check("t5_ovr1", ovr1, 1);
      check("t5_din1", din1, 8'h5A);
      check("t5_wait1", wait1, 0);
      check("t5_cnt1", cnt1, 1);
      tick();
      tick();
      check("t5_din3", din3, 8'h5A);
      check("t5_cnt3", cnt3, 1);
      check("t5_ovr3", ovr3, 1);

      // wrong index ignored
      ioctl_index = 8'd0;
      tick();
      ram_q      = 8'h11;
      ioctl_addr = 25'h003;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      ram_ack  = 1'b1;
      tick();
      ram_ack = 1'b0;
      check("t5_idx_wait", wait1, 0);
      check("t5_idx_req", req1, 0);
      tick();
      tick();
      tick();
      check("t5_idx_din", din1, 8'h5A);
      check("t5_idx_din_oor", ioctl_addr == 25'h003 ? din3 : 8'h00, 8'h5A);

      // full region session, done pulses once
      ioctl_index = 8'd4;
      tick();
      for (int a = 0; a < 1024; a++) begin
         do_read(25'(a), 8'(a) ^ 8'h5A);
         if (a == 0) check("t6_din_first", din1, 8'h5A);
      end
      check("t6_din_last", din3, 8'hA5);
      check("t6_cnt1", cnt1, 1024);
      check("t6_cnt3", cnt3, 1024);
      ioctl_upload = 1'b0;
      done_n = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done1) done_n++;
      end
      check("t6_done_pulses", done_n, 1);

      // one byte short, done stays low
      ioctl_upload = 1'b1;
      tick();
      for (int a = 0; a < 1023; a++) do_read(25'(a), 8'(a));
      check("t6b_cnt", cnt1, 1023);
      ioctl_upload = 1'b0;
      done_n = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done1 || done3) done_n++;
      end
      check("t6b_done_pulses", done_n, 0);

      // async reset mid-REQ
      ioctl_upload = 1'b1;
      tick();
      ioctl_addr = 25'h00A;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      check("t7_in_req", req1, 1);
      #2;
      RESET = 1'b1;
      #1;
      check("t7_req", req1, 0);
      check("t7_wait", wait1, 0);
      check("t7_din", din1, 8'h00);
      check("t7_addr", raddr1, 10'h000);
      check("t7_cnt", cnt1, 0);
      check("t7_ovr", ovr1, 0);
      tick();
      RESET = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hiscore_upload_reader.md
Name: hiscore_upload_reader

Overview:
- Serves HPS ioctl upload requests by reading a core-side RAM region, e.g. hiscore/NVRAM, and returning bytes on ioctl_din.
- It is the read-back counterpart of the ROM/DIP download path.
- Sits in emu between hps_io upload signals and an arbitrated read port on core work RAM.
- The core grants RAM access only when safe, e.g. vblank, so the block stalls the HPS with ioctl_wait until data is valid.

Parameters:
ADDR_W, 10, address width of the uploadable region (region size 2^ADDR_W bytes)
RAM_LAT, 1, core RAM read latency in cycles after grant; legal 1..3
UP_INDEX, 8'd4, ioctl_index value that selects this block

Ports:
CLK  in  1  system clock (clk_sys)
RESET  in  1  asynchronous, active-high reset
ioctl_upload  in  1  HPS upload session active
ioctl_index  in  8  upload target index
ioctl_rd  in  1  one-cycle byte read strobe
ioctl_addr  in  25  byte address of the read
ioctl_din  out  8  returned byte
ioctl_wait  out  1  stall HPS while high
ram_req  out  1  request core RAM read port
ram_ack  in  1  one-cycle grant; address is sampled by RAM on this cycle
ram_addr  out  ADDR_W  RAM read address
ram_q  in  8  RAM read data
byte_count  out  ADDR_W+1  in-range bytes served this session, saturating
rd_overrun  out  1  sticky: ioctl_rd arrived while busy
done  out  1  one-cycle pulse: session ended after full region served

Behaviour:
- Reset (async): state IDLE; ioctl_din=0, ioctl_wait=0, ram_req=0, ram_addr=0, byte_count=0, rd_overrun=0, done=0.
- sel = ioctl_upload & (ioctl_index==UP_INDEX). Every action below requires sel; when sel is 0, ioctl_rd is ignored.
- FSM states: IDLE, REQ, LAT.
- IDLE, on ioctl_rd & sel:
  - Out of range (ioctl_addr[24:ADDR_W] != 0): ioctl_din <= 8'hFF next edge. No wait, no RAM access, byte_count unchanged.
  - In range: ram_addr <= ioctl_addr[ADDR_W-1:0], ioctl_wait <= 1, go REQ.
- REQ: ram_req=1 (registered, set on entry). On ram_ack: ram_req <= 0, load latency counter with RAM_LAT-1, go LAT. There is no timeout; the block waits for grant indefinitely.
- LAT: ram_q is valid RAM_LAT cycles after the ack cycle. On that edge: ioctl_din <= ram_q, ioctl_wait <= 0, byte_count <= byte_count+1 (saturate at 2^ADDR_W), go IDLE.
- Latency, rd at cycle 0 with ack at cycle 1: ioctl_wait is high for cycles 1..1+RAM_LAT and low at cycle 2+RAM_LAT, with ioctl_din valid at that point. Each extra cycle of grant delay adds one cycle.
- ioctl_rd while not IDLE: ignored; rd_overrun <= 1.
- Upload rising edge (sel 0->1): byte_count <= 0, rd_overrun <= 0.
- Upload falling edge or index change (sel 1->0):
  - In any state: go IDLE, ram_req <= 0, ioctl_wait <= 0.
  - ioctl_din keeps its last value and no byte is counted.
  - done pulses for one cycle iff byte_count == 2^ADDR_W at that edge.
- ram_ack while not in REQ: ignored.
- Simultaneous ram_ack and sel falling: abort wins, no capture.
- Repeated reads of the same address are all counted; byte_count counts served reads, not unique addresses.

Decomposition:
- Shared package (pacman_pkg): state enum {IDLE, REQ, LAT}; UP_INDEX default constant; HISCORE_ADDR_W default.
- One natural sub-module: upload_edge_det, a registered rise/fall detector on sel producing session start/end pulses. Everything else stays inline.

Test Plan:
- RAM_LAT=1, immediate ack: upload idx 4, rd addr 0x005, ram_q=0xA5, ack the cycle after rd -> ram_addr=5; wait high exactly 2 cycles; ioctl_din=0xA5; byte_count=1.
- Delayed grant: ack held off 10 cycles, RAM_LAT=3 -> wait high 13 cycles; ram_req high 10 cycles then low; din captured 3 cycles after ack.
- Out of range: rd addr 0x400 (ADDR_W=10) -> din=0xFF next cycle; wait never asserted; ram_req never asserted; byte_count unchanged.
- Full session: 1024 sequential reads then upload low -> byte_count=1024, done pulses once. Repeat with 1023 reads -> done stays 0.
- Abort: upload drops while in REQ, and separately in the same cycle as ram_ack -> IDLE, ram_req=0, wait=0, din unchanged, byte_count unchanged.
- Protocol: rd during LAT -> rd_overrun=1 and the in-flight read completes normally; wrong index (idx 0) rd -> no response; async RESET mid-REQ -> all outputs 0 immediately.
